bilinear_pixel_blend: RTL and testbench

//  Consumer of the bilinear weight generator: takes the four neighbour pixels and the four
//  Q0.FIX_WIDTH weights w00/w01/w10/w11 and produces one interpolated pixel per beat.

---
 rtl/scaler_pkg.sv | 22 ++
 rtl/bilinear_channel_mac.sv | 66 ++++++
 rtl/bilinear_pixel_blend.sv | 82 ++++++++
 tb/tb_bilinear_pixel_blend.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// Shared scaler definitions: default widths and the round-half-up / saturate helper
// used by the bilinear weight generator and the pixel blender.
package scaler_pkg;

  localparam int unsigned FIX_WIDTH_DEF  = 12;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned CHANNELS_DEF   = 3;
  localparam int unsigned USER_WIDTH_DEF = 2;

  // Drop fix_w fraction bits with round half-up, then clamp to the data_w full-scale value.
  function automatic logic [31:0] round_sat(input logic [63:0] sum,
                                            input int unsigned fix_w,
                                            input int unsigned data_w);
    logic [63:0] q;
    logic [63:0] max_v;
    q     = (sum >> fix_w) + ((sum >> (fix_w - 1)) & 64'd1);
    max_v = (64'd1 << data_w) - 64'd1;
    if (q > max_v) q = max_v;
    return 32'(q);
  endfunction

endpackage

// File: rtl/bilinear_channel_mac.sv
// Single-channel bilinear blend datapath: products, pairwise sums, final sum with
// round/saturate. All three stages advance together on en_i.
module bilinear_channel_mac
  import scaler_pkg::*;
#(
  parameter int unsigned FIX_WIDTH  = FIX_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] p00_i,
  input  logic [DATA_WIDTH-1:0] p01_i,
  input  logic [DATA_WIDTH-1:0] p10_i,
  input  logic [DATA_WIDTH-1:0] p11_i,
  input  logic [FIX_WIDTH-1:0]  w00_i,
  input  logic [FIX_WIDTH-1:0]  w01_i,
  input  logic [FIX_WIDTH-1:0]  w10_i,
  input  logic [FIX_WIDTH-1:0]  w11_i,
  output logic [DATA_WIDTH-1:0] pix_o
);

  localparam int unsigned PW  = DATA_WIDTH + FIX_WIDTH;
  localparam int unsigned SW1 = PW + 1;
  localparam int unsigned SW2 = PW + 2;

  logic [3:0][PW-1:0]    prod_q, prod_d;
  logic [SW1-1:0]        top_q, top_d;
  logic [SW1-1:0]        bot_q, bot_d;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;
  logic [SW2-1:0]        sum_c;

  always_comb begin
    prod_d = prod_q;
    top_d  = top_q;
    bot_d  = bot_q;
    pix_d  = pix_q;
    sum_c  = SW2'(top_q) + SW2'(bot_q);
    if (en_i) begin
      prod_d[0] = PW'(p00_i) * PW'(w00_i);
      prod_d[1] = PW'(p01_i) * PW'(w01_i);
      prod_d[2] = PW'(p10_i) * PW'(w10_i);
      prod_d[3] = PW'(p11_i) * PW'(w11_i);
      top_d     = SW1'(prod_q[0]) + SW1'(prod_q[1]);
      bot_d     = SW1'(prod_q[2]) + SW1'(prod_q[3]);
      pix_d     = DATA_WIDTH'(round_sat(64'(sum_c), FIX_WIDTH, DATA_WIDTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q <= '0;
      top_q  <= '0;
      bot_q  <= '0;
      pix_q  <= '0;
    end else begin
      prod_q <= prod_d;
      top_q  <= top_d;
      bot_q  <= bot_d;
      pix_q  <= pix_d;
    end
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/bilinear_pixel_blend.sv
// Bilinear pixel blender: per-channel MAC pipelines plus shared valid/user/stall control.
// Three-stage pipeline, one pixel per clock, global stall when the output is held.
module bilinear_pixel_blend
  import scaler_pkg::*;
#(
  parameter int unsigned FIX_WIDTH  = FIX_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CHANNELS   = CHANNELS_DEF,
  parameter int unsigned USER_WIDTH = USER_WIDTH_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  input  logic [DATA_WIDTH*CHANNELS-1:0] p00_i,
  input  logic [DATA_WIDTH*CHANNELS-1:0] p01_i,
  input  logic [DATA_WIDTH*CHANNELS-1:0] p10_i,
  input  logic [DATA_WIDTH*CHANNELS-1:0] p11_i,
  input  logic [FIX_WIDTH-1:0]           w00_i,
  input  logic [FIX_WIDTH-1:0]           w01_i,
  input  logic [FIX_WIDTH-1:0]           w10_i,
  input  logic [FIX_WIDTH-1:0]           w11_i,
  input  logic [USER_WIDTH-1:0]          s_user_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [DATA_WIDTH*CHANNELS-1:0] m_pixel_o,
  output logic [USER_WIDTH-1:0]          m_user_o
);

  logic [2:0]                 vld_q, vld_d;
  logic [2:0][USER_WIDTH-1:0] user_q, user_d;
  logic                       en_c;

  // The pipeline only stalls when the output holds a beat downstream has not taken.
  assign en_c      = ~vld_q[2] | m_ready_i;
  assign s_ready_o = en_c;

  always_comb begin
    vld_d  = vld_q;
    user_d = user_q;
    if (en_c) begin
      vld_d     = {vld_q[1:0], s_valid_i};
      user_d[0] = s_user_i;
      user_d[1] = user_q[0];
      user_d[2] = user_q[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      user_q <= '0;
    end else begin
      vld_q  <= vld_d;
      user_q <= user_d;
    end
  end

  assign m_valid_o = vld_q[2];
  assign m_user_o  = user_q[2];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    bilinear_channel_mac #(
      .FIX_WIDTH (FIX_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_mac (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .en_i (en_c),
      .p00_i(p00_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .p01_i(p01_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .p10_i(p10_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .p11_i(p11_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .w00_i(w00_i),
      .w01_i(w01_i),
      .w10_i(w10_i),
      .w11_i(w11_i),
      .pix_o(m_pixel_o[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_bilinear_pixel_blend.sv
// Directed bench for bilinear_pixel_blend: latency, rounding, saturation, channel
// independence, stall handling, mid-stream reset and back-to-back throughput.
module tb_bilinear_pixel_blend;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] p00 = '0, p01 = '0, p10 = '0, p11 = '0;
  logic [11:0] w00 = '0, w01 = '0, w10 = '0, w11 = '0;
  logic [1:0]  s_user = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [23:0] m_pixel;
  logic [1:0]  m_user;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bilinear_pixel_blend dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .p00_i    (p00),
    .p01_i    (p01),
    .p10_i    (p10),
    .p11_i    (p11),
    .w00_i    (w00),
    .w01_i    (w01),
    .w10_i    (w10),
    .w11_i    (w11),
    .s_user_i (s_user),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .m_pixel_o(m_pixel),
    .m_user_o (m_user)
  );

  function automatic logic [23:0] rep(input logic [7:0] x);
    return {x, x, x};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic set_beat(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c,
                          input logic [23:0] d, input logic [11:0] v0, input logic [11:0] v1,
                          input logic [11:0] v2, input logic [11:0] v3, input logic [1:0] u);
    p00 = a; p01 = b; p10 = c; p11 = d;
    w00 = v0; w01 = v1; w10 = v2; w11 = v3;
    s_user = u;
  endtask

  // One isolated beat; the result is expected on the third clock after acceptance.
  task automatic run_one(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] c, input logic [23:0] d, input logic [11:0] v0,
                         input logic [11:0] v1, input logic [11:0] v2, input logic [11:0] v3,
                         input logic [23:0] exp_pix);
    @(negedge clk);
    set_beat(a, b, c, d, v0, v1, v2, v3, 2'd1);
    s_valid = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_valid"}, 32'(m_valid), 32'd1);
    check({tag, "_pixel"}, 32'(m_pixel), 32'(exp_pix));
    @(negedge clk);
  endtask

  // Stream n pass-through beats (w00 = full scale), optionally stalling the output.
  task automatic run_stream(input string tag, input int n, input int stall_at,
                            input int stall_len, output int span);
    logic [25:0] exp_q[$];
    logic [25:0] held;
    logic [25:0] front;
    logic        held_v;
    logic [7:0]  v;
    int          sent, got, cyc, first, last;
    held_v = 1'b0; held = '0;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      m_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (sent < n) begin
        v = 8'(sent * 20 + 7);
        set_beat(rep(v), rep(8'd99), rep(8'd42), rep(8'd17), 12'd4095, 12'd0, 12'd0, 12'd0,
                 2'(sent));
        s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (held_v) check({tag, "_stable"}, 32'({m_user, m_pixel}), 32'(held));
      held_v = m_valid && !m_ready;
      held   = {m_user, m_pixel};
      if (held_v) check({tag, "_ready_low"}, 32'(s_ready), 32'd0);
      if (m_valid && m_ready) begin
        front = (exp_q.size() > 0) ? exp_q.pop_front() : 26'h3ffffff;
        check({tag, "_out"}, 32'({m_user, m_pixel}), 32'(front));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back({2'(sent), rep(8'(sent * 20 + 7))});
        sent++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check({tag, "_count"}, 32'(got), 32'(n));
    span = last - first + 1;
  endtask

  initial begin
    int span;
    int seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_pixel", 32'(m_pixel), 32'd0);
    check("rst_m_user", 32'(m_user), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd1);

    // Exact latency with w00 at full scale
    set_beat(rep(8'd200), '0, '0, '0, 12'd4095, 12'd0, 12'd0, 12'd0, 2'd2);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("lat_c1", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("lat_c2", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("lat_c3", 32'(m_valid), 32'd1);
    check("lat_pixel", 32'(m_pixel), 32'(rep(8'd200)));
    check("lat_user", 32'(m_user), 32'd2);
    @(negedge clk);
    check("lat_drain", 32'(m_valid), 32'd0);

    // Averaging, rounding and saturation
    run_one("avg4", rep(8'd10), rep(8'd20), rep(8'd30), rep(8'd40),
            12'd1024, 12'd1024, 12'd1024, 12'd1024, rep(8'd25));
    run_one("avg4_frac", rep(8'd11), rep(8'd20), rep(8'd30), rep(8'd40),
            12'd1024, 12'd1024, 12'd1024, 12'd1024, rep(8'd25));
    run_one("sat", rep(8'd255), rep(8'd255), rep(8'd255), rep(8'd255),
            12'd4095, 12'd4095, 12'd4095, 12'd4095, rep(8'd255));
    run_one("round_half_up", rep(8'd1), '0, '0, '0, 12'd2048, 12'd0, 12'd0, 12'd0, rep(8'd1));
    run_one("round_below_half", rep(8'd1), '0, '0, '0, 12'd2047, 12'd0, 12'd0, 12'd0,
            rep(8'd0));
    run_one("chan_indep", {8'd255, 8'd100, 8'd0}, '0, '0, '0, 12'd4095, 12'd0, 12'd0, 12'd0,
            {8'd255, 8'd100, 8'd0});
    run_one("mix_weights", rep(8'd100), rep(8'd200), rep(8'd0), rep(8'd0),
            12'd2048, 12'd1024, 12'd0, 12'd0, rep(8'd100));

    // Stall mid-stream
    run_stream("stall", 10, 4, 5, span);

    // Reset with beats in flight
    @(negedge clk);
    set_beat(rep(8'd50), '0, '0, '0, 12'd4095, 12'd0, 12'd0, 12'd0, 2'd3);
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(m_valid), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    check("midrst_none_after", 32'(seen), 32'd0);

    // Back-to-back throughput and sideband alignment
    run_stream("b2b", 10, 1000, 0, span);
    check("b2b_span", 32'(span), 32'd10);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
